// File: rtl/rename_stage_if.sv
// Decode-side, retire-side and issue-side signals of the rename stage.
// The master drives decode and retire inputs; the slave (rename_stage) drives the renamed outputs.
interface rename_stage_if #(
  parameter int unsigned NUM_TAGS      = 64,
  parameter int unsigned NUM_TAGS_LOG2 = $clog2(NUM_TAGS)
);
  logic                     stall_in;
  logic                     in_valid;
  logic [3:0]               in_op;
  logic [4:0]               in_rd;
  logic [4:0]               in_rs1;
  logic [4:0]               in_rs2;
  logic                     in_use_imm;
  logic [31:0]              in_imm;
  logic                     retire_valid;
  logic [NUM_TAGS_LOG2-1:0] retire_tag_old;

  logic                     out_valid;
  logic [3:0]               out_op;
  logic [31:0]              out_imm;
  logic [NUM_TAGS_LOG2-1:0] out_tag_rd;
  logic [NUM_TAGS_LOG2-1:0] out_tag_rs1;
  logic [NUM_TAGS_LOG2-1:0] out_tag_rs2;
  logic [NUM_TAGS_LOG2-1:0] out_tag_old_rd;
  logic                     rename_stall;
  logic [NUM_TAGS_LOG2:0]   free_count;

  modport master (
    output stall_in, in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
           retire_valid, retire_tag_old,
    input  out_valid, out_op, out_imm, out_tag_rd, out_tag_rs1, out_tag_rs2, out_tag_old_rd,
           rename_stall, free_count
  );

  modport slave (
    input  stall_in, in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
           retire_valid, retire_tag_old,
    output out_valid, out_op, out_imm, out_tag_rd, out_tag_rs1, out_tag_rs2, out_tag_old_rd,
           rename_stall, free_count
  );
endinterface

// File: rtl/rename_stage.sv
// Register rename: RAT lookup/update, circular free list of physical tags, and a
// registered output stage feeding the issue queue. Tag 0 is permanently x0.
module rename_stage #(
  parameter int unsigned NUM_TAGS      = 64,
  parameter int unsigned NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
  parameter int unsigned ARCH_REGS     = 32
) (
  input logic           clk,
  input logic           rst,
  rename_stage_if.slave bus
);
  localparam int unsigned TW = NUM_TAGS_LOG2;
  localparam int unsigned CW = NUM_TAGS_LOG2 + 1;
  localparam int unsigned InitFree = NUM_TAGS - ARCH_REGS;
  localparam logic [CW-1:0] FullCount = CW'(NUM_TAGS);

  logic [TW-1:0] rat_q [ARCH_REGS];
  logic [TW-1:0] fl_q [NUM_TAGS];
  logic [TW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;

  logic          out_valid_q;
  logic [3:0]    out_op_q;
  logic [31:0]   out_imm_q;
  logic [TW-1:0] out_tag_rd_q, out_tag_rs1_q, out_tag_rs2_q, out_tag_old_rd_q;

  logic          need_alloc, stall, accept, pop, push;
  logic [TW-1:0] src1_tag, src2_tag, old_rd_tag, head_tag;

  always_comb begin
    need_alloc = bus.in_valid & (bus.in_rd != 5'd0);
    // Same-cycle retire deliberately does not bypass into allocation.
    stall      = bus.stall_in | (need_alloc & (count_q == '0));
    accept     = bus.in_valid & ~stall;
    pop        = accept & need_alloc;
    push       = bus.retire_valid & (bus.retire_tag_old != '0) & (count_q != FullCount);
    src1_tag   = rat_q[bus.in_rs1];
    src2_tag   = (bus.in_use_imm || bus.in_rs2 == 5'd0) ? '0 : rat_q[bus.in_rs2];
    old_rd_tag = rat_q[bus.in_rd];
    head_tag   = fl_q[head_q];
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) begin
        rat_q[i] <= TW'(i);
      end
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
        fl_q[i] <= (i < int'(InitFree)) ? TW'(i + int'(ARCH_REGS)) : '0;
      end
      head_q  <= '0;
      tail_q  <= TW'(InitFree);
      count_q <= CW'(InitFree);
    end else begin
      if (pop) begin
        rat_q[bus.in_rd] <= head_tag;
        head_q           <= head_q + 1'b1;
      end
      if (push) begin
        fl_q[tail_q] <= bus.retire_tag_old;
        tail_q       <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_op_q         <= '0;
      out_imm_q        <= '0;
      out_tag_rd_q     <= '0;
      out_tag_rs1_q    <= '0;
      out_tag_rs2_q    <= '0;
      out_tag_old_rd_q <= '0;
    end else if (!bus.stall_in) begin
      out_valid_q <= accept;
      if (accept) begin
        out_op_q         <= bus.in_op;
        out_imm_q        <= bus.in_imm;
        out_tag_rs1_q    <= src1_tag;
        out_tag_rs2_q    <= src2_tag;
        out_tag_rd_q     <= need_alloc ? head_tag : '0;
        out_tag_old_rd_q <= need_alloc ? old_rd_tag : '0;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_op         = out_op_q;
  assign bus.out_imm        = out_imm_q;
  assign bus.out_tag_rd     = out_tag_rd_q;
  assign bus.out_tag_rs1    = out_tag_rs1_q;
  assign bus.out_tag_rs2    = out_tag_rs2_q;
  assign bus.out_tag_old_rd = out_tag_old_rd_q;
  assign bus.rename_stall   = stall;
  assign bus.free_count     = count_q;
endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: a vector table from reset, then hand sequences for
// stall hold, free-list exhaustion/refill and head/tail wrap.
module tb_rename_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_stage_if #(.NUM_TAGS(64)) bus ();
  rename_stage #(.NUM_TAGS(64), .ARCH_REGS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        vld;  logic [3:0] op;  logic [4:0] rd;  logic [4:0] rs1;  logic [4:0] rs2;
    logic        imm_en;  logic [31:0] imm;  logic ret;  logic [5:0] rtag;  logic stall;
    logic        e_stall;  logic e_vld;  logic [5:0] e_rd;  logic [5:0] e_old;
    logic [5:0]  e_rs1;  logic [5:0] e_rs2;  logic [3:0] e_op;  logic [31:0] e_imm;
    logic [6:0]  e_fc;
  } vec_t;

  vec_t       vt [11];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [5:0] q [$];
  logic [5:0] exp_rd;
  logic [5:0] rtag;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic imm_en,
                       input logic [31:0] imm, input logic ret, input logic [5:0] rt,
                       input logic stall);
    bus.in_valid       = vld;
    bus.in_op          = op;
    bus.in_rd          = rd;
    bus.in_rs1         = rs1;
    bus.in_rs2         = rs2;
    bus.in_use_imm     = imm_en;
    bus.in_imm         = imm;
    bus.retire_valid   = ret;
    bus.retire_tag_old = rt;
    bus.stall_in       = stall;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string n, input logic vld, input logic [5:0] rd,
                           input logic [5:0] old, input logic [5:0] rs1, input logic [5:0] rs2,
                           input logic [3:0] op, input logic [31:0] imm, input logic [6:0] fc);
    check({n, ".valid"}, 64'(bus.out_valid), 64'(vld));
    check({n, ".tag_rd"}, 64'(bus.out_tag_rd), 64'(rd));
    check({n, ".tag_old_rd"}, 64'(bus.out_tag_old_rd), 64'(old));
    check({n, ".tag_rs1"}, 64'(bus.out_tag_rs1), 64'(rs1));
    check({n, ".tag_rs2"}, 64'(bus.out_tag_rs2), 64'(rs2));
    check({n, ".op"}, 64'(bus.out_op), 64'(op));
    check({n, ".imm"}, 64'(bus.out_imm), 64'(imm));
    check({n, ".free_count"}, 64'(bus.free_count), 64'(fc));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    //        vld op rd rs1 rs2 ie imm ret rt st | e_st e_v rd old rs1 rs2 op imm fc
    vt[0]  = '{1, 2, 5, 5, 0, 1, 7,  0, 0, 0,  0, 1, 32, 5, 5,  0,  2, 7,  31};
    vt[1]  = '{1, 1, 6, 5, 5, 0, 0,  0, 0, 0,  0, 1, 33, 6, 32, 32, 1, 0,  30};
    vt[2]  = '{0, 3, 7, 1, 2, 0, 0,  0, 0, 0,  0, 0, 33, 6, 32, 32, 1, 0,  30};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 33, 6, 32, 32, 1, 0,  30};
    vt[4]  = '{1, 4, 0, 3, 4, 0, 0,  0, 0, 0,  0, 1, 0,  0, 3,  4,  4, 0,  30};
    vt[5]  = '{1, 5, 3, 0, 6, 0, 0,  0, 0, 0,  0, 1, 34, 3, 0,  33, 5, 0,  29};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0,  1, 5, 0,  0, 0, 34, 3, 0,  33, 5, 0,  30};
    vt[7]  = '{1, 6, 8, 3, 0, 0, 99, 1, 6, 0,  0, 1, 35, 8, 34, 0,  6, 99, 30};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 35, 8, 34, 0,  6, 99, 30};
    vt[9]  = '{1, 7, 9, 8, 3, 0, 0,  1, 7, 1,  1, 0, 35, 8, 34, 0,  6, 99, 31};
    vt[10] = '{1, 7, 9, 8, 3, 0, 0,  0, 0, 0,  0, 1, 36, 9, 35, 34, 7, 0,  30};

    apply_reset();
    check_out("reset", 0, 0, 0, 0, 0, 0, 0, 32);
    check("reset.rename_stall", 64'(bus.rename_stall), 64'(0));

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].vld, vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm_en, vt[i].imm,
            vt[i].ret, vt[i].rtag, vt[i].stall);
      #1;
      check($sformatf("vec%0d.rename_stall", i), 64'(bus.rename_stall), 64'(vt[i].e_stall));
      step();
      check_out($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_rd, vt[i].e_old, vt[i].e_rs1,
                vt[i].e_rs2, vt[i].e_op, vt[i].e_imm, vt[i].e_fc);
    end

    // Mid-stream reset discards state; then stall_in frozen for 3 cycles.
    apply_reset();
    check_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 32);
    drive(1, 1, 5, 1, 2, 0, 0, 0, 0, 0);
    step();
    check_out("add_x5", 1, 32, 5, 1, 2, 1, 0, 31);
    for (int c = 0; c < 3; c++) begin
      drive(1, 2, 6, 5, 3, 0, 11, 0, 0, 1);
      #1;
      check($sformatf("hold%0d.rename_stall", c), 64'(bus.rename_stall), 64'(1));
      step();
      check_out($sformatf("hold%0d", c), 1, 32, 5, 1, 2, 1, 0, 31);
    end
    drive(1, 2, 6, 5, 3, 0, 11, 0, 0, 0);
    step();
    check_out("after_hold", 1, 33, 6, 32, 3, 2, 11, 30);

    // Exhaust the free list, then refill with one retired tag.
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 5'((i % 31) + 1), 0, 0, 0, 0, 0, 0, 0);
      step();
      check($sformatf("drain%0d.tag_rd", i), 64'(bus.out_tag_rd), 64'(32 + i));
      check($sformatf("drain%0d.free_count", i), 64'(bus.free_count), 64'(31 - i));
    end
    drive(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("empty.rename_stall", 64'(bus.rename_stall), 64'(1));
    step();
    check("empty.valid", 64'(bus.out_valid), 64'(0));
    check("empty.free_count", 64'(bus.free_count), 64'(0));
    drive(1, 1, 10, 0, 0, 0, 0, 1, 5, 0);
    #1;
    check("no_bypass.rename_stall", 64'(bus.rename_stall), 64'(1));
    step();
    check("no_bypass.valid", 64'(bus.out_valid), 64'(0));
    check("no_bypass.free_count", 64'(bus.free_count), 64'(1));
    drive(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("refill.rename_stall", 64'(bus.rename_stall), 64'(0));
    step();
    check_out("refill", 1, 5, 41, 0, 0, 1, 0, 0);
    drive(1, 3, 0, 1, 2, 0, 0, 0, 0, 0);
    #1;
    check("x0_empty.rename_stall", 64'(bus.rename_stall), 64'(0));
    step();
    check_out("x0_empty", 1, 0, 0, 63, 33, 3, 0, 0);

    // Bring free_count to 10, then allocate+retire every cycle across the wrap point.
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      drive(1, 1, 5'((i % 31) + 1), 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    check("fc10", 64'(bus.free_count), 64'(10));
    q.delete();
    for (int t = 54; t < 64; t++) q.push_back(6'(t));
    for (int k = 0; k < 61; k++) begin
      rtag = (k == 0) ? 6'd7 : 6'(((k * 7) % 63) + 1);
      drive(1, 1, 5'((k % 31) + 1), 0, 0, 0, 0, 1, rtag, 0);
      step();
      exp_rd = q.pop_front();
      q.push_back(rtag);
      check($sformatf("wrap%0d.tag_rd", k), 64'(bus.out_tag_rd), 64'(exp_rd));
      check($sformatf("wrap%0d.free_count", k), 64'(bus.free_count), 64'(10));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
# rename_stage

Register-rename stage between decode and the issue queue. Maps architectural registers to physical tags through a register alias table (RAT), allocates destination tags from a circular free list, and returns retired tags to that list. Presents one renamed instruction per cycle on a registered output whose fields (op, tag_rd, tag_rs1, tag_rs2, imm, valid) feed the issue queue inputs directly. Tag 0 is permanently bound to x0; the issue queue reads tag_rs2 == 0 as "src 2 is the immediate".

## Interface
- NUM_TAGS, 64, physical tag count; tag 0 reserved.
- NUM_TAGS_LOG2, $clog2(NUM_TAGS), tag width.
- ARCH_REGS, 32, architectural register count.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall_in  in  1  downstream (issue queue) stall; holds the output register.
- in_valid  in  1  decoded instruction valid.
- in_op  in  4  ALU select, passed through.
- in_rd, in_rs1, in_rs2  in  5 each  architectural register indices.
- in_use_imm  in  1  src 2 is the immediate.
- in_imm  in  32  immediate, passed through.
- retire_valid  in  1  ROB retires an instruction this cycle.
- retire_tag_old  in  NUM_TAGS_LOG2  previous mapping of the retired rd; freed.
- out_valid  out  1  renamed instruction valid.
- out_op  out  4; out_imm  out  32.
- out_tag_rd, out_tag_rs1, out_tag_rs2, out_tag_old_rd  out  NUM_TAGS_LOG2 each.
- rename_stall  out  1  combinational back-pressure to decode.
- free_count  out  NUM_TAGS_LOG2+1  number of tags in the free list.

## Operation
- Reset: RAT[i] = i for every i; free list holds tags ARCH_REGS..NUM_TAGS-1 in ascending order (head = 0, count = NUM_TAGS-ARCH_REGS = 32). All out_* = 0; free_count = 32.
- need_alloc = in_valid & (in_rd != 0).
- rename_stall = stall_in | (need_alloc & (free_count == 0)). The same-cycle retire does not bypass into allocation.
- accept = in_valid & !rename_stall.
- On accept:
  - out_tag_rs1 = RAT[in_rs1].
  - out_tag_rs2 = 0 if in_use_imm or in_rs2 == 0; otherwise RAT[in_rs2].
  - Sources read the RAT before this instruction's own update, so rs == rd returns the old tag.
  - If need_alloc: out_tag_rd = free list head, out_tag_old_rd = RAT[in_rd], RAT[in_rd] <= head, head increments.
  - Otherwise out_tag_rd = 0 and out_tag_old_rd = 0.
  - out_op and out_imm are copied; out_valid <= 1.
- RAT[0] is never written and always reads 0.
- Free list:
  - Circular buffer of NUM_TAGS entries with head and tail pointers that wrap modulo NUM_TAGS.
  - Retire push: when retire_valid and retire_tag_old != 0, write the tag at tail and increment tail. retire_tag_old == 0 is ignored.
  - free_count += push - pop; a simultaneous push and pop leaves the count unchanged.
  - A push when free_count == NUM_TAGS is a protocol error: it is dropped and the count saturates.
- stall_in = 1: all out_* hold, no RAT or free-list pop. Retire pushes still proceed.
- stall_in = 0 with no accept (in_valid = 0, or free-list stall): out_valid <= 0 next cycle; other out_* hold.

## Timing
- Latency: instruction accepted at edge N appears on out_* after edge N (valid during cycle N+1).
- Throughput: 1 instruction per cycle while free_count > 0 or rd == x0.
- Back-to-back dependency: instruction k+1 reading instruction k's rd sees k's new tag, because the RAT write at edge N is visible to lookup in cycle N+1.
- Freed tag: pushed at edge N, allocatable from cycle N+1.
- Reset mid-stream: at the next edge the RAT and free list reinitialise, out_valid = 0, and in-flight state is discarded.

## Test plan
- Reset, then "add x5,x1,x2" -> next cycle out_tag_rd = 32, out_tag_old_rd = 5, out_tag_rs1 = 1, out_tag_rs2 = 2, free_count = 31.
- "addi x5,x5,7" followed by "add x6,x5,x5" -> first gives rs1 = 5, rd = 32, rs2 = 0, imm = 7; second gives rs1 = rs2 = 32, rd = 33.
- 32 allocating instructions with no retire -> free_count = 0; the 33rd raises rename_stall and out_valid = 0. Retire tag 5 -> the 33rd is accepted the following cycle with rd = 5.
- stall_in held 3 cycles with in_valid = 1 -> out_* frozen, free_count constant, the instruction is accepted the cycle after stall_in falls.
- rd = x0 with the free list empty -> no stall, out_tag_rd = 0, free_count unchanged.
- Allocate and retire in the same cycle at free_count = 10 -> free_count stays 10. Drive head/tail wrap past index 63 -> tags are returned in FIFO order.
